// File: rtl/e_md_div_pkg.sv
// Shared types and constants for the E-stage iterative divider.
// Also holds the default iteration count that sets the divider width.
package e_md_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2
  } divState_e;

  localparam int DIV_ITER = 32;

endpackage

// File: rtl/e_md_div_if.sv
// Request/result bundle between the E-stage operand muxes, the divider and HILO.
// The master drives operands and control; the slave (the divider) returns status and results.
interface e_md_div_if
  import e_md_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             abort;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor, abort,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor, abort,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/e_md_absneg.sv
// Conditional two's-complement negate, shared by the divide and multiply units.
module e_md_absneg #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/e_md_div.sv
// Radix-2 restoring divider for DIV/DIVU: magnitudes are divided unsigned over
// WIDTH iterations, then a fix-up cycle restores signs and publishes LO/HI.
module e_md_div
  import e_md_div_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic       clk,
  input  logic       reset,
  e_md_div_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  divState_e        state_q;
  logic             signA_q;
  logic             signB_q;
  logic             divZero_q;
  logic [WIDTH-1:0] dividendOrig_q;
  logic [WIDTH-1:0] divisorMag_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             done_q;

  logic             signA_d;
  logic             signB_d;
  logic [WIDTH-1:0] magA_d;
  logic [WIDTH-1:0] magB_d;
  logic [WIDTH:0]   remShift_d;
  logic             fits_d;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic [WIDTH-1:0] quoFix_d;
  logic [WIDTH-1:0] remFix_d;

  assign signA_d = bus.dividend[WIDTH-1] & bus.is_signed;
  assign signB_d = bus.divisor[WIDTH-1] & bus.is_signed;

  e_md_absneg #(.WIDTH(WIDTH)) u_magA (.in_i(bus.dividend), .neg_i(signA_d), .out_o(magA_d));
  e_md_absneg #(.WIDTH(WIDTH)) u_magB (.in_i(bus.divisor),  .neg_i(signB_d), .out_o(magB_d));
  e_md_absneg #(.WIDTH(WIDTH)) u_fixQ (.in_i(quo_q), .neg_i(signA_q ^ signB_q), .out_o(quoFix_d));
  e_md_absneg #(.WIDTH(WIDTH)) u_fixR (.in_i(rem_q), .neg_i(signA_q),           .out_o(remFix_d));

  // When the trial subtraction fits, the difference is below the divisor, so WIDTH bits suffice.
  always_comb begin
    remShift_d = {rem_q, quo_q[WIDTH-1]};
    fits_d     = (remShift_d >= {1'b0, divisorMag_q});
    rem_d      = fits_d ? (remShift_d[WIDTH-1:0] - divisorMag_q) : remShift_d[WIDTH-1:0];
    quo_d      = {quo_q[WIDTH-2:0], fits_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= DIV_IDLE;
      signA_q        <= 1'b0;
      signB_q        <= 1'b0;
      divZero_q      <= 1'b0;
      dividendOrig_q <= '0;
      divisorMag_q   <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      count_q        <= '0;
      quotient_q     <= '0;
      remainder_q    <= '0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        DIV_IDLE: begin
          if (bus.start && !bus.abort) begin
            signA_q        <= signA_d;
            signB_q        <= signB_d;
            divZero_q      <= (bus.divisor == '0);
            dividendOrig_q <= bus.dividend;
            divisorMag_q   <= magB_d;
            rem_q          <= '0;
            quo_q          <= magA_d;
            count_q        <= '0;
            state_q        <= DIV_CALC;
          end
        end
        DIV_CALC: begin
          if (bus.abort) begin
            state_q <= DIV_IDLE;
          end else begin
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            count_q <= count_q + CNT_W'(1);
            if (count_q == CNT_W'(WIDTH - 1)) begin
              state_q <= DIV_FIX;
            end
          end
        end
        DIV_FIX: begin
          // Abort here still discards the result: HILO must keep its old contents.
          if (bus.abort) begin
            state_q <= DIV_IDLE;
          end else begin
            quotient_q  <= divZero_q ? '1 : quoFix_d;
            remainder_q <= divZero_q ? dividendOrig_q : remFix_d;
            done_q      <= 1'b1;
            state_q     <= DIV_IDLE;
          end
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q != DIV_IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;

endmodule

// File: tb/tb_e_md_div.sv
// Self-checking bench for e_md_div: directed vector table, corner-case sequences
// and random operands compared against an arithmetic reference model.
module tb_e_md_div;

  localparam int W = 32;
  localparam int LAT = W + 1;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  e_md_div_if #(.WIDTH(W)) bus ();

  e_md_div #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference: plain 64-bit arithmetic, which truncates toward zero with the remainder following the dividend.
  function automatic void refDiv(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa;
    longint sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end
  endfunction

  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
  endtask

  task automatic waitDone(output int lat, output int busyCnt, output logic timedOut);
    lat      = 0;
    busyCnt  = 0;
    timedOut = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.done) begin
        timedOut = 1'b0;
        lat      = k;
        break;
      end
      if (bus.busy) busyCnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic runAndCheck(input string name, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] q, input logic [W-1:0] r, input logic full);
    int   lat;
    int   busyCnt;
    logic timedOut;
    applyStimulus(sgn, a, b);
    waitDone(lat, busyCnt, timedOut);
    checkOutput({name, " timeout"}, W'(timedOut), '0);
    checkOutput({name, " quotient"}, bus.quotient, q);
    checkOutput({name, " remainder"}, bus.remainder, r);
    if (full) begin
      checkOutput({name, " latency"}, W'(lat), W'(LAT));
      checkOutput({name, " busy cycles"}, W'(busyCnt), W'(LAT));
      checkOutput({name, " busy at done"}, W'(bus.busy), '0);
    end
  endtask

  initial begin
    vec_t         vecs[$];
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;
    int           doneCnt;
    int           lat;
    int           busyCnt;
    logic         timedOut;

    total = 0;
    bad   = 0;
    clk   = 1'b0;
    reset = 1'b1;
    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.abort     = 1'b0;

    vecs.push_back('{1'b0, 32'd100,        32'd7,          32'd14,         32'd2});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD,   32'hFFFFFFFF});
    vecs.push_back('{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD,   32'h00000001});
    vecs.push_back('{1'b0, 32'h12345678,   32'h00000000,   32'hFFFFFFFF,   32'h12345678});
    vecs.push_back('{1'b1, 32'hFFFFFF00,   32'h00000000,   32'hFFFFFFFF,   32'hFFFFFF00});
    vecs.push_back('{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h00000000});
    vecs.push_back('{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF,   32'h00000000});
    vecs.push_back('{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h00000000,   32'h80000000});
    vecs.push_back('{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003,   32'hFFFFFFFF});

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset busy", W'(bus.busy), '0);
    checkOutput("reset done", W'(bus.done), '0);
    checkOutput("reset quotient", bus.quotient, '0);
    checkOutput("reset remainder", bus.remainder, '0);
    reset = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      runAndCheck($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d done width", i), W'(bus.done), '0);
    end

    // start and abort together: abort wins, nothing launches
    bus.abort = 1'b1;
    applyStimulus(1'b0, 32'd9, 32'd2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    checkOutput("start+abort busy", W'(bus.busy), '0);

    runAndCheck("prior 84/9", 1'b0, 32'd84, 32'd9, 32'd9, 32'd3, 1'b0);

    applyStimulus(1'b0, 32'd50, 32'd5);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    checkOutput("abort busy drop", W'(bus.busy), '0);
    doneCnt = 0;
    repeat (40) begin
      if (bus.done) doneCnt++;
      @(posedge clk); #1;
    end
    checkOutput("abort no done", W'(doneCnt), '0);
    checkOutput("abort keeps quotient", bus.quotient, 32'd9);
    checkOutput("abort keeps remainder", bus.remainder, 32'd3);
    runAndCheck("after abort 50/5", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b1);

    // start pulses while busy must not disturb the running divide
    applyStimulus(1'b0, 32'd1000, 32'd3);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 1; k < 100; k++) begin
      if (k == 5 || k == 15) applyStimulus(1'b1, 32'd77, 32'd2);
      else bus.start = 1'b0;
      @(posedge clk); #1;
      if (bus.done) break;
    end
    bus.start = 1'b0;
    checkOutput("ignored start done", W'(bus.done), 32'd1);
    checkOutput("ignored start quotient", bus.quotient, 32'd333);
    checkOutput("ignored start remainder", bus.remainder, 32'd1);
    @(posedge clk); #1;
    checkOutput("ignored start idle", W'(bus.busy), '0);

    // back-to-back: second start is issued in the done cycle of the first
    runAndCheck("b2b first", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b1);
    runAndCheck("b2b second", 1'b0, 32'd1234567, 32'd1000, 32'd1234, 32'd567, 1'b1);

    // reset in the middle of a divide clears everything on the next edge
    applyStimulus(1'b0, 32'd999, 32'd4);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("mid reset busy", W'(bus.busy), '0);
    checkOutput("mid reset done", W'(bus.done), '0);
    checkOutput("mid reset quotient", bus.quotient, '0);
    checkOutput("mid reset remainder", bus.remainder, '0);
    @(posedge clk); #1;

    for (int n = 0; n < 40; n++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      case ($urandom_range(0, 4))
        0: rb = W'($urandom_range(1, 15));
        1: rb = $urandom;
        2: rb = $urandom >> $urandom_range(0, 31);
        3: rb = -W'($urandom_range(1, 15));
        default: rb = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'h0;
      endcase
      refDiv(rs, ra, rb, eq, er);
      applyStimulus(rs, ra, rb);
      waitDone(lat, busyCnt, timedOut);
      checkOutput($sformatf("rand%0d timeout", n), W'(timedOut), '0);
      checkOutput($sformatf("rand%0d quotient s=%0d a=%08h b=%08h", n, rs, ra, rb), bus.quotient, eq);
      checkOutput($sformatf("rand%0d remainder s=%0d a=%08h b=%08h", n, rs, ra, rb), bus.remainder, er);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
